quad_decoder: RTL

- Quadrature encoder front-end that drives the control side of the team's up/down loadable counter: en, up_down, load_en and load_count.
- Turns the asynchronous encoder phases A/B and the index line into clean single-cycle step and load strobes.
- Sits between the encoder pins and the counter, which holds the position.

---
 rtl/quad_decoder_pkg.sv | 55 +++++
 rtl/quad_decoder_if.sv | 14 +
 rtl/quad_decoder_input_filter.sv | 79 +++++++
 rtl/quad_decoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/quad_decoder_pkg.sv
// Shared types and helpers for the quadrature decoder: phase encoding and
// the step classification used when two accepted phases are compared.
package quad_decoder_pkg;

    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic valid;
        logic illegal;
        logic dir;
    } step_t;

    // Position of a phase along the up-counting Gray cycle 00->10->11->01.
    function automatic logic [1:0] phase_pos(input phase_t p);
        logic [1:0] pos;
        pos = 2'd0;
        case (p)
            PH_00:   pos = 2'd0;
            PH_10:   pos = 2'd1;
            PH_11:   pos = 2'd2;
            PH_01:   pos = 2'd3;
            default: pos = 2'd0;
        endcase
        return pos;
    endfunction

    function automatic step_t step_dir(input phase_t prev, input phase_t curr);
        step_t      res;
        logic [1:0] delta;
        res   = '0;
        delta = phase_pos(curr) - phase_pos(prev);
        case (delta)
            2'd1: begin
                res.valid = 1'b1;
                res.dir   = DIR_UP;
            end
            2'd3: begin
                res.valid = 1'b1;
                res.dir   = DIR_DOWN;
            end
            2'd2:    res.illegal = 1'b1;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Counter-control bus produced by the quadrature decoder and consumed by
// the up/down loadable counter.
interface quad_decoder_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             upDown;
    logic             loadEn;
    logic [WIDTH-1:0] loadCount;
    logic             err;

    modport master (output en, upDown, loadEn, loadCount, err);
    modport slave  (input  en, upDown, loadEn, loadCount, err);
endinterface

// File: rtl/quad_decoder_input_filter.sv
// Synchronizer plus glitch filter for one asynchronous encoder line; valid_o
// marks that the accepted value reflects real input since reset.
module quad_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic raw_i,
    output logic filt_o,
    output logic valid_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   acc_q, acc_d;
    logic [CW-1:0]          run_q, run_d;
    logic [CW-1:0]          prime_q, prime_d;
    logic                   valid_q, valid_d;
    logic                   synced;
    logic                   filled;

    assign synced = sync_q[SYNC_STAGES-1];
    assign filled = fill_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sync_q  <= '0;
            fill_q  <= '0;
            acc_q   <= 1'b0;
            run_q   <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            acc_q   <= acc_d;
            run_q   <= run_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
        end
    end

    // A value equal to the reset state never produces an update, so priming
    // separately counts stable cycles of real (post-synchronizer) data.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
        fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
        acc_d   = acc_q;
        run_d   = run_q;
        prime_d = prime_q;
        valid_d = valid_q;
        if (synced != acc_q) begin
            prime_d = '0;
            if (run_q == RUN_LAST) begin
                acc_d   = synced;
                run_d   = '0;
                valid_d = 1'b1;
            end else begin
                run_d = run_q + 1'b1;
            end
        end else begin
            run_d = '0;
            if (!valid_q && filled) begin
                if (prime_q == RUN_LAST) begin
                    valid_d = 1'b1;
                end else begin
                    prime_d = prime_q + 1'b1;
                end
            end
        end
    end

    assign filt_o  = acc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: conditions A/B/index and issues registered
// step, direction, load and sticky error signals to the position counter.
module quad_decoder
    import quad_decoder_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               FILTER_LEN  = 4,
    parameter bit               INDEX_EN    = 1'b1,
    parameter logic [WIDTH-1:0] INDEX_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             quad_a_i,
    input  logic             quad_b_i,
    input  logic             index_i,
    input  logic             err_clr_i,
    output logic             en_o,
    output logic             up_down_o,
    output logic             load_en_o,
    output logic [WIDTH-1:0] load_count_o,
    output logic             err_o
);
    logic   accA, accB, accIdx;
    logic   validA, validB, validIdx;
    phase_t curr;
    step_t  step;

    phase_t prev_q, prev_d;
    logic   init_q, init_d;
    logic   idxPrev_q, idxPrev_d;
    logic   en_q, en_d;
    logic   upDown_q, upDown_d;
    logic   loadEn_q, loadEn_d;
    logic   err_q, err_d;

    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) uFilterA (
        .clk_i(clk_i), .rstn_i(rstn_i), .raw_i(quad_a_i), .filt_o(accA), .valid_o(validA)
    );
    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) uFilterB (
        .clk_i(clk_i), .rstn_i(rstn_i), .raw_i(quad_b_i), .filt_o(accB), .valid_o(validB)
    );
    quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) uFilterIdx (
        .clk_i(clk_i), .rstn_i(rstn_i), .raw_i(index_i), .filt_o(accIdx), .valid_o(validIdx)
    );

    assign curr = phase_t'({accA, accB});
    assign step = step_dir(prev_q, curr);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            prev_q    <= PH_00;
            init_q    <= 1'b1;
            idxPrev_q <= 1'b0;
            en_q      <= 1'b0;
            upDown_q  <= DIR_UP;
            loadEn_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            init_q    <= init_d;
            idxPrev_q <= idxPrev_d;
            en_q      <= en_d;
            upDown_q  <= upDown_d;
            loadEn_q  <= loadEn_d;
            err_q     <= err_d;
        end
    end

    // The first valid phase after reset seeds the comparison silently; after
    // that every accepted phase is decoded and becomes the new reference,
    // including illegal jumps so the decoder resynchronizes.
    always_comb begin
        prev_d    = prev_q;
        init_d    = init_q;
        en_d      = 1'b0;
        upDown_d  = upDown_q;
        err_d     = err_q;
        idxPrev_d = accIdx;
        loadEn_d  = 1'b0;
        if (init_q) begin
            if (validA && validB) begin
                prev_d = curr;
                init_d = 1'b0;
            end
        end else begin
            prev_d = curr;
            if (step.valid) begin
                en_d     = 1'b1;
                upDown_d = step.dir;
            end
        end
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (!init_q && step.illegal) begin
            err_d = 1'b1;
        end
        if (INDEX_EN && validIdx && accIdx && !idxPrev_q) begin
            loadEn_d = 1'b1;
        end
    end

    assign en_o         = en_q;
    assign up_down_o    = upDown_q;
    assign load_en_o    = loadEn_q;
    assign load_count_o = INDEX_VALUE;
    assign err_o        = err_q;

endmodule
